// File: rtl/cache_control_if.sv
// CPU, tag/data array and memory signals seen by the cache controller.
// Counter outputs exist only when CACHE_PERF_CNT_EN is defined.
interface cache_control_if;
    logic mem_read;
    logic mem_write;
    logic mem_resp;
    logic hit;
    logic valid;
    logic dirty;
    logic load_data;
    logic load_tag;
    logic load_valid;
    logic load_dirty;
    logic dirty_in;
    logic data_sel;
    logic pmem_read;
    logic pmem_write;
    logic pmem_resp;
    logic addr_sel;
`ifdef CACHE_PERF_CNT_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
    logic [31:0] wb_count;
`endif

    modport master (
        input  mem_read,
        input  mem_write,
        input  hit,
        input  valid,
        input  dirty,
        input  pmem_resp,
        output mem_resp,
        output load_data,
        output load_tag,
        output load_valid,
        output load_dirty,
        output dirty_in,
        output data_sel,
        output pmem_read,
        output pmem_write,
        output addr_sel
`ifdef CACHE_PERF_CNT_EN
        ,
        output hit_count,
        output miss_count,
        output wb_count
`endif
    );

    modport slave (
        output mem_read,
        output mem_write,
        output hit,
        output valid,
        output dirty,
        output pmem_resp,
        input  mem_resp,
        input  load_data,
        input  load_tag,
        input  load_valid,
        input  load_dirty,
        input  dirty_in,
        input  data_sel,
        input  pmem_read,
        input  pmem_write,
        input  addr_sel
`ifdef CACHE_PERF_CNT_EN
        ,
        input  hit_count,
        input  miss_count,
        input  wb_count
`endif
    );
endinterface

// File: rtl/cache_control.sv
// Write-back cache controller FSM: IDLE / WRITEBACK / ALLOCATE.
// Optional saturating perf counters when CACHE_PERF_CNT_EN is defined.
module cache_control (
    input logic             clk,
    input logic             rst,
    cache_control_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } state_e;

    state_e state_q;
    state_e state_d;

    logic req;
    logic wr;

    // A simultaneous read and write is handled as a write.
    assign req = bus.mem_read | bus.mem_write;
    assign wr  = bus.mem_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        bus.mem_resp   = 1'b0;
        bus.load_data  = 1'b0;
        bus.load_tag   = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_dirty = 1'b0;
        bus.dirty_in   = 1'b0;
        bus.data_sel   = 1'b0;
        bus.pmem_read  = 1'b0;
        bus.pmem_write = 1'b0;
        bus.addr_sel   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (bus.hit) begin
                        bus.mem_resp = 1'b1;
                        if (wr) begin
                            bus.load_data  = 1'b1;
                            bus.load_dirty = 1'b1;
                            bus.dirty_in   = 1'b1;
                        end
                    end else if (bus.valid && bus.dirty) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                bus.pmem_write = 1'b1;
                bus.addr_sel   = 1'b1;
                if (bus.pmem_resp) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                bus.pmem_read = 1'b1;
                // Refill lands on the response cycle; line comes back clean.
                if (bus.pmem_resp) begin
                    bus.load_data  = 1'b1;
                    bus.data_sel   = 1'b1;
                    bus.load_tag   = 1'b1;
                    bus.load_valid = 1'b1;
                    bus.load_dirty = 1'b1;
                    state_d        = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef CACHE_PERF_CNT_EN
    logic        hit_ev;
    logic        miss_ev;
    logic        wb_ev;
    logic [31:0] hit_cnt_q;
    logic [31:0] hit_cnt_d;
    logic [31:0] miss_cnt_q;
    logic [31:0] miss_cnt_d;
    logic [31:0] wb_cnt_q;
    logic [31:0] wb_cnt_d;

    assign hit_ev  = (state_q == IDLE) && req && bus.hit;
    assign miss_ev = (state_q == IDLE) && req && !bus.hit;
    assign wb_ev   = (state_q == WRITEBACK) && bus.pmem_resp;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        wb_cnt_d   = wb_cnt_q;
        if (hit_ev && (hit_cnt_q != 32'hFFFF_FFFF)) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
        if (miss_ev && (miss_cnt_q != 32'hFFFF_FFFF)) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
        if (wb_ev && (wb_cnt_q != 32'hFFFF_FFFF)) begin
            wb_cnt_d = wb_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
            wb_cnt_q   <= 32'd0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            wb_cnt_q   <= wb_cnt_d;
        end
    end

    assign bus.hit_count  = hit_cnt_q;
    assign bus.miss_count = miss_cnt_q;
    assign bus.wb_count   = wb_cnt_q;
`endif

endmodule

// File: doc/cache_control.md
CACHE_CONTROL -- requirements
Module: cache_control

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high (clock clk).
REQ-002 SHALL have CPU ports: mem_read  in  1  read request; mem_write  in  1  write request; mem_resp  out  1  request complete.
REQ-003 SHALL have datapath status ports: hit  in  1  indexed tag matches and valid; valid  in  1  indexed line valid; dirty  in  1  indexed line dirty.
REQ-004 SHALL have array control ports: load_data, load_tag, load_valid, load_dirty  out  1 each  write strobes; dirty_in  out  1  dirty value written; data_sel  out  1  0 = CPU write data, 1 = memory line.
REQ-005 SHALL have memory ports: pmem_read  out  1; pmem_write  out  1; pmem_resp  in  1  memory transfer done; addr_sel  out  1  0 = CPU line address, 1 = victim tag address.
REQ-006 SHALL have, only when CACHE_PERF_CNT_EN is defined: hit_count, miss_count, wb_count  out  32 each.

Function
REQ-007 SHALL implement states IDLE, WRITEBACK, ALLOCATE; state register updates on posedge clk only.
REQ-008 SHALL drive all outputs combinationally from state and inputs; every output not listed as asserted in a state/condition SHALL be 0.
REQ-009 IDLE, (mem_read|mem_write) & hit: mem_resp=1 same cycle (zero-wait hit); remain IDLE.
REQ-010 IDLE, mem_write & hit: also load_data=1, data_sel=0, load_dirty=1, dirty_in=1.
REQ-011 IDLE, request & !hit & valid & dirty: next state WRITEBACK; no strobes, mem_resp=0.
REQ-012 IDLE, request & !hit & !(valid & dirty): next state ALLOCATE; no strobes, mem_resp=0.
REQ-013 WRITEBACK: pmem_write=1, addr_sel=1 every cycle; on pmem_resp next state ALLOCATE, else stay.
REQ-014 ALLOCATE: pmem_read=1, addr_sel=0 every cycle; on pmem_resp assert load_data=1, data_sel=1, load_tag=1, load_valid=1, load_dirty=1, dirty_in=0; next state IDLE.
REQ-015 After ALLOCATE the request SHALL be re-evaluated in IDLE; a held request then hits and completes (miss latency = refill cycles + 1, plus writeback cycles if dirty).
REQ-016 mem_read and mem_write both asserted SHALL be treated as a write.
REQ-017 CPU holds request and address stable until mem_resp; request dropped mid-miss SHALL NOT abort an in-flight memory transfer; the state sequence completes and returns to IDLE.
REQ-018 pmem_read and pmem_write SHALL never be asserted in the same cycle.
REQ-019 pmem_resp while in IDLE SHALL be ignored.

Reset
REQ-020 rst sampled high SHALL force state IDLE on that edge, including mid-WRITEBACK or mid-ALLOCATE; pmem_read/pmem_write SHALL be 0 the cycle after.
REQ-021 With rst high and no request, all outputs SHALL be 0; counters (if present) SHALL reset to 0.

Configuration
REQ-022 Macro CACHE_PERF_CNT_EN defined: hit_count increments on each REQ-009 completion, miss_count on each IDLE->WRITEBACK/ALLOCATE transition, wb_count on each WRITEBACK exit; all saturate at 32'hFFFF_FFFF.
REQ-023 Macro undefined: counters and their ports SHALL not exist; all other behaviour identical.

Verification
REQ-024 Reset, then mem_read=1, hit=1 -> mem_resp=1 same cycle, all strobes 0, state stays IDLE.
REQ-025 mem_write=1, hit=1 -> mem_resp=1, load_data=1, data_sel=0, load_dirty=1, dirty_in=1 in one cycle.
REQ-026 mem_read=1, hit=0, valid=1, dirty=0, pmem_resp after 3 cycles -> pmem_read high 3 cycles with addr_sel=0, refill strobes on resp cycle, then hit=1 -> mem_resp next cycle; miss_count=1.
REQ-027 mem_write=1, hit=0, valid=1, dirty=1, pmem_resp after 2 cycles per transfer -> pmem_write 2 cycles with addr_sel=1, then pmem_read 2 cycles, never overlapping; wb_count=1.
REQ-028 rst asserted in the second cycle of ALLOCATE -> state IDLE next cycle, pmem_read=0, no refill strobes, counters 0.
